// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - load/run/check controller bus: start, program load, expected table, CPU and RAM port, status
interface cpu_run_ctrl_if #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 500,
  parameter int NUM_CHECKS = 2
);
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  logic              start;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              chk_wr;
  logic [IDX_W-1:0]  chk_idx;
  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] chk_exp;
  logic              cpu_reset;
  logic              cpu_halt;
  logic              mem_own;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;
  logic [IDX_W:0]    fail_count;
  logic [IDX_W-1:0]  fail_idx;

  // Driver side: load source, CPU and RAM environment
  modport master (
    output start, ld_valid, ld_addr, ld_data, ld_last,
    output chk_wr, chk_idx, chk_addr, chk_exp,
    output cpu_halt, mem_rdata,
    input  ld_ready, cpu_reset, mem_own, mem_we, mem_addr, mem_wdata,
    input  busy, done, pass, timeout, cycle_count, fail_count, fail_idx
  );

  // Controller side
  modport slave (
    input  start, ld_valid, ld_addr, ld_data, ld_last,
    input  chk_wr, chk_idx, chk_addr, chk_exp,
    input  cpu_halt, mem_rdata,
    output ld_ready, cpu_reset, mem_own, mem_we, mem_addr, mem_wdata,
    output busy, done, pass, timeout, cycle_count, fail_count, fail_idx
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - program load / run / self-check controller for the cpu; MEM_CLEAR_EN adds RAM zero-fill before load
module cpu_run_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 500,
  parameter int NUM_CHECKS = 2
) (
  input logic           clk,
  input logic           reset,
  cpu_run_ctrl_if.slave ctrl_if
);
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_CHECK, S_DONE
  } state_t;

`ifdef MEM_CLEAR_EN
  localparam state_t START_STATE = S_CLEAR;
`else
  localparam state_t START_STATE = S_LOAD;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              timeout_q, timeout_d;
  logic [IDX_W:0]    fail_cnt_q, fail_cnt_d;
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              phase_q, phase_d;  // 0: present address, 1: compare read data
`ifdef MEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

  logic [ADDR_W-1:0] tbl_addr_q [NUM_CHECKS];
  logic [DATA_W-1:0] tbl_exp_q  [NUM_CHECKS];

  // Expected-result table; frozen while it is being consumed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_addr_q[i] <= '0;
        tbl_exp_q[i]  <= '0;
      end
    end else if (ctrl_if.chk_wr && (state_q != S_CHECK) &&
                 (int'(ctrl_if.chk_idx) < NUM_CHECKS)) begin
      tbl_addr_q[ctrl_if.chk_idx] <= ctrl_if.chk_addr;
      tbl_exp_q[ctrl_if.chk_idx]  <= ctrl_if.chk_exp;
    end
  end

  // State and sequence registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      timeout_q  <= 1'b0;
      fail_cnt_q <= '0;
      fail_idx_q <= '0;
      idx_q      <= '0;
      phase_q    <= 1'b0;
`ifdef MEM_CLEAR_EN
      clr_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      timeout_q  <= timeout_d;
      fail_cnt_q <= fail_cnt_d;
      fail_idx_q <= fail_idx_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
`ifdef MEM_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

  // Next-state logic and RAM/CPU port control
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    timeout_d  = timeout_q;
    fail_cnt_d = fail_cnt_q;
    fail_idx_d = fail_idx_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
`ifdef MEM_CLEAR_EN
    clr_addr_d = clr_addr_q;
`endif
    ctrl_if.ld_ready  = 1'b0;
    ctrl_if.cpu_reset = 1'b1;
    ctrl_if.mem_own   = 1'b1;
    ctrl_if.mem_we    = 1'b0;
    ctrl_if.mem_addr  = '0;
    ctrl_if.mem_wdata = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (ctrl_if.start) begin
          state_d    = START_STATE;
          cyc_d      = '0;
          timeout_d  = 1'b0;
          fail_cnt_d = '0;
          fail_idx_d = '0;
          idx_d      = '0;
          phase_d    = 1'b0;
`ifdef MEM_CLEAR_EN
          clr_addr_d = '0;
`endif
        end
      end
      S_CLEAR: begin
`ifdef MEM_CLEAR_EN
        ctrl_if.mem_we   = 1'b1;
        ctrl_if.mem_addr = clr_addr_q;
        clr_addr_d       = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = S_LOAD;
`else
        state_d = S_LOAD;
`endif
      end
      S_LOAD: begin
        ctrl_if.ld_ready  = 1'b1;
        ctrl_if.mem_we    = ctrl_if.ld_valid;
        ctrl_if.mem_addr  = ctrl_if.ld_addr;
        ctrl_if.mem_wdata = ctrl_if.ld_data;
        if (ctrl_if.ld_valid && ctrl_if.ld_last) state_d = S_RUN;
      end
      S_RUN: begin
        ctrl_if.cpu_reset = 1'b0;
        ctrl_if.mem_own   = 1'b0;
        // Count this clock; the limit is never exceeded so the counter saturates.
        if (cyc_q != CNT_W'(MAX_CYCLES)) cyc_d = cyc_q + 1'b1;
        if (ctrl_if.cpu_halt) begin
          state_d = S_CHECK;
        end else if (cyc_q == CNT_W'(MAX_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        // Address held over both cycles so the sync read lines up in the second.
        ctrl_if.mem_addr = tbl_addr_q[idx_q];
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (ctrl_if.mem_rdata != tbl_exp_q[idx_q]) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
            if (fail_cnt_q == '0) fail_idx_d = idx_q;
          end
          if (idx_q == IDX_W'(NUM_CHECKS - 1)) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ctrl_if.busy        = (state_q == S_CLEAR) || (state_q == S_LOAD) ||
                               (state_q == S_RUN)   || (state_q == S_CHECK);
  assign ctrl_if.done        = (state_q == S_DONE);
  assign ctrl_if.pass        = (state_q == S_DONE) && (fail_cnt_q == '0) && !timeout_q;
  assign ctrl_if.timeout     = timeout_q;
  assign ctrl_if.cycle_count = cyc_q;
  assign ctrl_if.fail_count  = fail_cnt_q;
  assign ctrl_if.fail_idx    = fail_idx_q;
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Synthesizable program-load / run / self-check controller for the von Neumann `cpu`.
- Parametrised in data width, address width, timeout and number of result checks.
- Owns the unified RAM port while the CPU is held in reset. In order it:
  - streams a program image into the RAM;
  - releases the CPU and runs it until Halt or timeout;
  - reads back NUM_CHECKS result locations and compares them against a programmed expected table.
- Sits between the load source (UART/JTAG bridge or sim driver) and `cpu`/datapath memory mux.

Parameters:
DATA_W, 16, RAM/register word width
ADDR_W, 8, RAM address width (depth 2^ADDR_W)
MAX_CYCLES, 500, run-phase timeout in clocks (>=1)
NUM_CHECKS, 2, entries in expected-result table (>=1)
(derived: CNT_W = clog2(MAX_CYCLES+1), IDX_W = max(1, clog2(NUM_CHECKS)))

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  1-cycle pulse: begin load sequence; ignored unless IDLE or DONE
ld_valid  in  1  program word valid
ld_ready  out  1  controller accepts program word
ld_addr  in  ADDR_W  program word address
ld_data  in  DATA_W  program word
ld_last  in  1  final program word; qualifies with ld_valid&&ld_ready
chk_wr  in  1  write expected-table entry (any state except CHECK)
chk_idx  in  IDX_W  table index
chk_addr  in  ADDR_W  RAM address to check
chk_exp  in  DATA_W  expected value
cpu_reset  out  1  active-high hold to cpu reset input
cpu_halt  in  1  Halt from cpu control unit
mem_own  out  1  1 = controller drives RAM port, 0 = CPU drives it
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr (sync read)
busy  out  1  sequence in progress
done  out  1  sequence complete; held until next start
pass  out  1  all checks matched and no timeout; valid when done
timeout  out  1  run ended by MAX_CYCLES
cycle_count  out  CNT_W  clocks spent in RUN
fail_count  out  IDX_W+1  number of mismatching checks
fail_idx  out  IDX_W  index of first mismatch (0 if none)

Behaviour:
- Reset (async, reset=0):
  - state IDLE; cpu_reset=1, mem_own=1, mem_we=0, ld_ready=0, busy=0, done=0, pass=0, timeout=0, counters 0, fail_idx=0.
  - Expected table cleared to 0.
  - Mid-operation reset aborts immediately; the CPU stays held.
- States:
  - IDLE -start-> CLEAR (MEM_CLEAR_EN) or LOAD.
  - CLEAR: mem_we=1, mem_wdata=0, address counter 0..2^ADDR_W-1, one word per clock. After the last address -> LOAD.
  - LOAD: ld_ready=1.
    - Each ld_valid&&ld_ready writes ld_data to ld_addr the same cycle (mem_we=1).
    - A handshake with ld_last -> RUN.
    - No timeout in LOAD.
  - RUN: mem_own=0, cpu_reset=0, cycle_count increments every clock.
    - cpu_halt=1 -> CHECK; timeout stays 0.
    - Otherwise, when cycle_count reaches MAX_CYCLES -> timeout=1 -> CHECK.
    - Halt and the limit in the same cycle: halt wins, timeout=0.
    - cycle_count saturates and is frozen at exit.
  - CHECK: cpu_reset=1, mem_own=1. For idx 0..NUM_CHECKS-1:
    - cycle A drives mem_addr=chk_addr[idx];
    - cycle B compares mem_rdata with chk_exp[idx];
    - 2 clocks per entry, so 2*NUM_CHECKS clocks total.
    - On mismatch: fail_count++; on the first mismatch, fail_idx=idx.
    - Checks always run, including after timeout.
  - DONE: done=1, busy=0, pass = (fail_count==0) && !timeout. start -> clears status/counters, then same path as IDLE.
- busy=1 in CLEAR, LOAD, RUN, CHECK.
- start while busy is ignored.
- chk_wr during CHECK is ignored.
- LOAD address beyond 2^ADDR_W-1 is impossible (port width); repeated addresses overwrite.

Optional Feature:
- MEM_CLEAR_EN defined:
  - CLEAR state present; RAM is zero-filled before LOAD.
  - Load latency is +2^ADDR_W clocks.
- Undefined:
  - start goes straight to LOAD.
  - Unwritten RAM keeps prior contents.

Test Plan:
- Load sample program (ends HLT), table {0x20->0x0008, R-store addr->0x000D}, start -> halt before 500 clocks, done=1, pass=1, fail_count=0, timeout=0.
- Program that loops forever (JMP self), MAX_CYCLES=500 -> timeout=1, cycle_count=500, checks still executed, pass=0.
- Expected[1]=0x000E with correct program -> fail_count=1, fail_idx=1, pass=0; cycle_count equals the halting run's value.
- ld_valid toggled with gaps, ld_last on word 12 -> exactly 12 RAM writes, RUN entered the cycle after the ld_last handshake.
- Reset asserted in RUN at cycle 37 -> cpu_reset=1, busy=0, done=0 at once; a new start replays cleanly.
- MEM_CLEAR_EN build, RAM prefilled 0xFFFF, 3-word load -> unloaded addresses read 0x0000; start-to-ld_ready latency is 256+1 clocks.
